// File: rtl/norm_shift_unit.sv
// norm_shift_unit
// ---------------------------------------------------------------------------
// Normalization shifter for a floating-point add/sub datapath. It takes the
// unnormalized significand and the leading-zero estimate from the LZA. It
// left-justifies the significand, corrects the LZA's possible one-bit
// underestimate, and adjusts the biased exponent to match.
//
// Pipeline (initiation interval 1, no stalls):
//   S1  capture operands and clamp the shift estimate to SWR-1
//   S2  coarse left shift by the estimate with its two LSBs cleared
//   S3  fine left shift by estimate[1:0], one-bit correction, exponent update
// A load in cycle N produces Valid_o in cycle N+3.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   FSM_load_i     one-cycle strobe that captures a new operand set
//   Shift_Value_i  left-shift estimate from the LZA          [EW]
//   Data_i         unnormalized significand                 [SWR]
//   Exp_i          biased exponent before normalization      [EW]
//   Data_o         normalized significand                   [SWR]
//   Exp_o          adjusted biased exponent                  [EW]
//   Zero_o         captured significand was zero
//   Underflow_o    adjusted exponent reached or crossed zero
//   Valid_o        one-cycle pulse; the result outputs were updated this cycle
// ---------------------------------------------------------------------------
module norm_shift_unit #(
  parameter int unsigned SWR = 26,
  parameter int unsigned EW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           FSM_load_i,
  input  logic [EW-1:0]  Shift_Value_i,
  input  logic [SWR-1:0] Data_i,
  input  logic [EW-1:0]  Exp_i,
  output logic [SWR-1:0] Data_o,
  output logic [EW-1:0]  Exp_o,
  output logic           Zero_o,
  output logic           Underflow_o,
  output logic           Valid_o
);

  // -------------------------------------------------------------------------
  // S1: capture
  // -------------------------------------------------------------------------
  logic [EW-1:0]  shift_clamp;

  logic           s1_valid_q;
  logic [SWR-1:0] s1_data_q;
  logic [EW-1:0]  s1_exp_q;
  logic [EW-1:0]  s1_shift_q;

  // The LZA estimate can exceed the significand width. Shifting past SWR-1
  // would push every bit out, so the estimate is limited here.
  always_comb begin
    shift_clamp = Shift_Value_i;
    if (32'(Shift_Value_i) > SWR - 1) begin
      shift_clamp = EW'(SWR - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      s1_shift_q <= '0;
    end else begin
      s1_valid_q <= FSM_load_i;
      if (FSM_load_i) begin
        s1_data_q  <= Data_i;
        s1_exp_q   <= Exp_i;
        s1_shift_q <= shift_clamp;
      end
    end
  end

  // -------------------------------------------------------------------------
  // S2: coarse shift (multiple of four)
  // -------------------------------------------------------------------------
  logic [EW-1:0]  coarse_amt;
  logic [SWR-1:0] coarse_data;

  logic           s2_valid_q;
  logic [SWR-1:0] s2_data_q;
  logic [EW-1:0]  s2_exp_q;
  logic [EW-1:0]  s2_shift_q;
  logic           s2_zero_q;

  always_comb begin
    coarse_amt  = {s1_shift_q[EW-1:2], 2'b00};
    coarse_data = s1_data_q << coarse_amt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_exp_q   <= '0;
      s2_shift_q <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= coarse_data;
      s2_exp_q   <= s1_exp_q;
      s2_shift_q <= s1_shift_q;
      // Zero is judged on the captured operand and not on the shifted value.
      s2_zero_q  <= (s1_data_q == '0);
    end
  end

  // -------------------------------------------------------------------------
  // S3: fine shift, LZA correction, exponent adjustment
  // -------------------------------------------------------------------------
  logic [SWR-1:0]       fine_data;
  logic [SWR-1:0]       norm_data;
  logic                 corr;
  logic signed [EW:0]   exp_adj;
  logic                 exp_nonpos;

  logic [SWR-1:0]       data_d;
  logic [EW-1:0]        exp_d;
  logic                 zero_d;
  logic                 underflow_d;

  always_comb begin
    fine_data = s2_data_q << s2_shift_q[1:0];
    norm_data = fine_data;
    corr      = 1'b0;
    // The LZA may come up one position short. A nonzero result whose MSB is
    // still clear needs exactly one more shift.
    if ((fine_data != '0) && !fine_data[SWR-1]) begin
      norm_data = fine_data << 1;
      corr      = 1'b1;
    end

    // Signed EW+1-bit arithmetic so that borrowing below zero is visible.
    exp_adj    = $signed({1'b0, s2_exp_q}) - $signed({1'b0, s2_shift_q})
               - $signed({{EW{1'b0}}, corr});
    exp_nonpos = exp_adj[EW] || (exp_adj == '0);

    data_d      = norm_data;
    exp_d       = exp_adj[EW-1:0];
    zero_d      = 1'b0;
    underflow_d = 1'b0;

    if (s2_zero_q) begin
      data_d      = '0;
      exp_d       = '0;
      zero_d      = 1'b1;
      underflow_d = 1'b0;
    end else if (exp_nonpos) begin
      exp_d       = '0;
      underflow_d = 1'b1;
    end
  end

  // Result registers change only alongside the Valid_o pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      Valid_o     <= 1'b0;
      Data_o      <= '0;
      Exp_o       <= '0;
      Zero_o      <= 1'b0;
      Underflow_o <= 1'b0;
    end else begin
      Valid_o <= s2_valid_q;
      if (s2_valid_q) begin
        Data_o      <= data_d;
        Exp_o       <= exp_d;
        Zero_o      <= zero_d;
        Underflow_o <= underflow_d;
      end
    end
  end

endmodule

// File: tb/tb_norm_shift_unit.sv
// Directed testbench for norm_shift_unit (SWR=26, EW=8).
module tb_norm_shift_unit;

  localparam int unsigned SWR = 26;
  localparam int unsigned EW  = 8;

  logic           clk;
  logic           rst;
  logic           FSM_load_i;
  logic [EW-1:0]  Shift_Value_i;
  logic [SWR-1:0] Data_i;
  logic [EW-1:0]  Exp_i;
  logic [SWR-1:0] Data_o;
  logic [EW-1:0]  Exp_o;
  logic           Zero_o;
  logic           Underflow_o;
  logic           Valid_o;

  int n_cmp  = 0;
  int n_fail = 0;

  norm_shift_unit #(
    .SWR(SWR),
    .EW (EW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .FSM_load_i   (FSM_load_i),
    .Shift_Value_i(Shift_Value_i),
    .Data_i       (Data_i),
    .Exp_i        (Exp_i),
    .Data_o       (Data_o),
    .Exp_o        (Exp_o),
    .Zero_o       (Zero_o),
    .Underflow_o  (Underflow_o),
    .Valid_o      (Valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs and samples sit 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [SWR-1:0] d, input logic [EW-1:0] sh,
                       input logic [EW-1:0] e);
    FSM_load_i    = ld;
    Data_i        = d;
    Shift_Value_i = sh;
    Exp_i         = e;
  endtask

  task automatic check_out(input string tag, input logic [SWR-1:0] d, input logic [EW-1:0] e,
                           input logic z, input logic uf);
    check({tag, ".valid"}, 32'(Valid_o), 32'd1);
    check({tag, ".data"},  32'(Data_o), 32'(d));
    check({tag, ".exp"},   32'(Exp_o), 32'(e));
    check({tag, ".zero"},  32'(Zero_o), 32'(z));
    check({tag, ".uf"},    32'(Underflow_o), 32'(uf));
  endtask

  // Single isolated load: checks latency, result, and the single-cycle pulse.
  task automatic run_vec(input string tag, input logic [SWR-1:0] d, input logic [EW-1:0] sh,
                         input logic [EW-1:0] e, input logic [SWR-1:0] xd,
                         input logic [EW-1:0] xe, input logic xz, input logic xuf);
    drive(1'b1, d, sh, e);
    step();
    drive(1'b0, 26'h3ffffff, 8'hff, 8'hff);
    step();
    check({tag, ".early"}, 32'(Valid_o), 32'd0);
    step();
    check_out(tag, xd, xe, xz, xuf);
    step();
    check({tag, ".pulse"}, 32'(Valid_o), 32'd0);
    check({tag, ".hold"},  32'(Data_o), 32'(xd));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    step();
    step();
    check("rst.valid", 32'(Valid_o), 32'd0);
    check("rst.data",  32'(Data_o), 32'd0);
    check("rst.exp",   32'(Exp_o), 32'd0);
    check("rst.zero",  32'(Zero_o), 32'd0);
    check("rst.uf",    32'(Underflow_o), 32'd0);
    rst = 1'b0;
    step();
    check("idle.valid", 32'(Valid_o), 32'd0);

    run_vec("exact", 26'h0400000, 8'd3,  8'd100, 26'h2000000, 8'd97,  1'b0, 1'b0);
    run_vec("lza",   26'h0200000, 8'd3,  8'd100, 26'h2000000, 8'd96,  1'b0, 1'b0);
    run_vec("zero",  26'h0000000, 8'd26, 8'd50,  26'h0000000, 8'd0,   1'b1, 1'b0);
    run_vec("uflow", 26'h0000001, 8'd25, 8'd10,  26'h2000000, 8'd0,   1'b0, 1'b1);
    run_vec("clamp", 26'h0000001, 8'd40, 8'd200, 26'h2000000, 8'd175, 1'b0, 1'b0);
    // Fine shift of 2 plus coarse 4, exact estimate: bit 19 -> bit 25.
    run_vec("fine2", 26'h0080000, 8'd6,  8'd20,  26'h2000000, 8'd14,  1'b0, 1'b0);
    // Exponent lands exactly on zero.
    run_vec("ezero", 26'h0400000, 8'd3,  8'd3,   26'h2000000, 8'd0,   1'b0, 1'b1);

    // Back-to-back loads at cycles 0, 1, 2.
    drive(1'b1, 26'h0400000, 8'd3, 8'd100);
    step();
    drive(1'b1, 26'h0200000, 8'd3, 8'd100);
    step();
    drive(1'b1, 26'h0000001, 8'd25, 8'd10);
    step();
    drive(1'b0, '0, '0, '0);
    check_out("b2b0", 26'h2000000, 8'd97, 1'b0, 1'b0);
    step();
    check_out("b2b1", 26'h2000000, 8'd96, 1'b0, 1'b0);
    step();
    check_out("b2b2", 26'h2000000, 8'd0, 1'b0, 1'b1);
    step();
    check("b2b.end", 32'(Valid_o), 32'd0);

    // Same sequence with reset at cycle 2: everything in flight is dropped.
    drive(1'b1, 26'h0400000, 8'd3, 8'd100);
    step();
    drive(1'b1, 26'h0200000, 8'd3, 8'd100);
    step();
    drive(1'b1, 26'h0000001, 8'd25, 8'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rstf%0d.valid", i), 32'(Valid_o), 32'd0);
      check($sformatf("rstf%0d.data", i),  32'(Data_o), 32'd0);
      check($sformatf("rstf%0d.exp", i),   32'(Exp_o), 32'd0);
      check($sformatf("rstf%0d.zero", i),  32'(Zero_o), 32'd0);
      check($sformatf("rstf%0d.uf", i),    32'(Underflow_o), 32'd0);
      step();
    end

    // First load after reset behaves as after power-up.
    run_vec("post", 26'h0000001, 8'd40, 8'd200, 26'h2000000, 8'd175, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/norm_shift_unit.md
NORM_SHIFT_UNIT -- requirements
Module: norm_shift_unit

Interface
REQ-001 Parameter SWR, default 26, significand width in bits, equal to the width of the LZA P_i/G_i vectors.
REQ-002 Parameter EW, default 8, exponent width and shift-value width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 FSM_load_i  input  1  one-cycle strobe; captures a new operand set.
REQ-006 Shift_Value_i  input  EW  left-shift estimate from LZA Shift_Value_o.
REQ-007 Data_i  input  SWR  unnormalized add/sub result significand.
REQ-008 Exp_i  input  EW  biased exponent before normalization.
REQ-009 Data_o  output  SWR  normalized significand.
REQ-010 Exp_o  output  EW  adjusted biased exponent.
REQ-011 Zero_o  output  1  result significand is zero.
REQ-012 Underflow_o  output  1  exponent adjustment reached or crossed zero.
REQ-013 Valid_o  output  1  one-cycle pulse; outputs updated this cycle.

Function
REQ-014 The block shall be a 3-stage pipeline (S1 capture, S2 coarse shift, S3 fine shift plus correction); a load in cycle N produces Valid_o in cycle N+3.
REQ-015 The block shall accept FSM_load_i on every cycle (initiation interval 1); each load shall yield exactly one Valid_o pulse, in order.
REQ-016 The block shall advance the pipeline every cycle, with no stall input; stage valid bits shall shift one stage per cycle.
REQ-017 S1 shall register Data_i, Exp_i, and the effective shift S = min(Shift_Value_i, SWR-1) when FSM_load_i=1; S1 valid shall equal FSM_load_i.
REQ-018 S2 shall left-shift the significand by S with the two LSBs cleared (multiple of 4), zero-filling.
REQ-019 S3 shall left-shift by S[1:0].
REQ-020 After the S3 shift, if the result is nonzero and its MSB is 0, S3 shall shift left one further bit and set correction c=1; otherwise c=0. This covers the LZA one-bit underestimate.
REQ-021 The exponent shall be computed in EW+1-bit signed arithmetic as E = Exp_i - S - c.
REQ-022 If E <= 0 and the significand is nonzero: Exp_o=0, Underflow_o=1, and Data_o is the shifted significand.
REQ-023 If E > 0: Exp_o = E[EW-1:0] and Underflow_o=0.
REQ-024 If captured Data_i == 0: Data_o=0, Exp_o=0, Zero_o=1, Underflow_o=0, c=0, regardless of S.
REQ-025 Data_o, Exp_o, Zero_o and Underflow_o shall update only in cycles where Valid_o=1, and shall hold their values otherwise.
REQ-026 Valid_o shall be 1 for exactly one cycle per result, never asserted without a corresponding load.

Reset
REQ-027 When rst=1, all stage valid bits shall clear and Data_o=0, Exp_o=0, Zero_o=0, Underflow_o=0, Valid_o=0 on the next edge.
REQ-028 rst shall take priority over FSM_load_i in the same cycle; that load is dropped.
REQ-029 In-flight operations at reset shall be discarded; no Valid_o shall appear for them after rst deasserts.
REQ-030 The first load after rst deasserts shall behave identically to a load after power-up.

Verification (SWR=26, EW=8)
REQ-031 Exact shift: Data_i=26'h0400000, Shift_Value_i=3, Exp_i=100 -> at N+3 Valid_o=1, Data_o=26'h2000000, Exp_o=97, Zero_o=0, Underflow_o=0.
REQ-032 LZA underestimate: Data_i=26'h0200000, Shift_Value_i=3, Exp_i=100 -> Data_o=26'h2000000, Exp_o=96.
REQ-033 Zero input: Data_i=0, Shift_Value_i=26, Exp_i=50 -> Data_o=0, Exp_o=0, Zero_o=1, Underflow_o=0.
REQ-034 Underflow: Data_i=26'h0000001, Shift_Value_i=25, Exp_i=10 -> Data_o=26'h2000000, Exp_o=0, Underflow_o=1.
REQ-035 Clamp: Data_i=26'h0000001, Shift_Value_i=40, Exp_i=200 -> shift clamped to 25, Data_o=26'h2000000, Exp_o=175.
REQ-036 Back-to-back and reset: loads at cycles 0, 1 and 2 -> Valid_o at cycles 3, 4 and 5 with in-order results; repeat with rst=1 at cycle 2 -> no Valid_o at cycles 3-5, and all outputs 0.
